// File: rtl/param_serializer.sv
// rtl/param_serializer.sv - double-buffered parallel-to-serial converter with parity, stall and abort
// A holding register takes the next word while the shift register drains, allowing gapless frames.
module param_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LVL   = 1'b1,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  in_ready,
  input  logic                  par_type,
  input  logic                  ser_en,
  input  logic                  ser_abort,
  output logic                  word_vld,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  par_bit
);

  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  sh_vld_q, sh_vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_q, par_d;
  logic                  load;

  assign ser_done = sh_vld_q && (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign load     = hold_vld_q && (!sh_vld_q || (ser_en && ser_done));
  assign in_ready = !hold_vld_q;
  assign word_vld = sh_vld_q;
  assign par_bit  = par_q;
  assign ser_data = !sh_vld_q ? IDLE_LVL
                  : (MSB_FIRST ? sh_q[DATA_WIDTH-1] : sh_q[0]);

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sh_d       = sh_q;
    sh_vld_d   = sh_vld_q;
    cnt_d      = cnt_q;
    par_d      = par_q;

    // Capture and load are mutually exclusive: load needs hold_vld, capture needs it clear.
    if (Data_Valid && !hold_vld_q) begin
      hold_d     = P_DATA;
      hold_vld_d = 1'b1;
    end

    if (ser_abort) begin
      sh_vld_d = 1'b0;
      cnt_d    = '0;
    end else if (load) begin
      sh_d       = hold_q;
      sh_vld_d   = 1'b1;
      cnt_d      = '0;
      hold_vld_d = 1'b0;
      par_d      = (^hold_q) ^ par_type;
    end else if (ser_en && sh_vld_q) begin
      if (ser_done) begin
        sh_vld_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (MSB_FIRST) begin
          sh_d = {sh_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
          sh_d = {1'b0, sh_q[DATA_WIDTH-1:1]};
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sh_q       <= '0;
      sh_vld_q   <= 1'b0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sh_q       <= sh_d;
      sh_vld_q   <= sh_vld_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
    end
  end

endmodule
